flap_controller: RTL and testbench

//  Game-level sequencer for the flap button. Consumes the registered key level from the

---
 rtl/flappy_pkg.sv | 14 +
 rtl/flap_controller_tick_down_counter.sv | 26 ++
 rtl/flap_controller.sv | 110 +++++++++++
 tb/tb_flap_controller.sv | 139 +++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared game-level types and default tick constants for the flappy datapath blocks.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } game_state_t;

    localparam int DEFAULT_CW              = 4;
    localparam int DEFAULT_COOLDOWN_TICKS  = 2;
    localparam int DEFAULT_DEAD_HOLD_TICKS = 8;

endpackage

// File: rtl/flap_controller_tick_down_counter.sv
// Loadable down-counter that steps once per frame tick and rests at zero.
module tick_down_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          tick,
    output logic [CW-1:0] count,
    output logic          zero
);

    // A load on the same edge as a tick takes priority over the decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (tick && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/flap_controller.sv
// Flap button sequencer: edge-detects the key, rate-limits flaps per frame tick and
// runs the IDLE/PLAY/DEAD game state machine with registered control outputs.
module flap_controller
    import flappy_pkg::*;
#(
    parameter int CW              = DEFAULT_CW,
    parameter int COOLDOWN_TICKS  = DEFAULT_COOLDOWN_TICKS,
    parameter int DEAD_HOLD_TICKS = DEFAULT_DEAD_HOLD_TICKS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_level,
    input  logic       tick,
    input  logic       collide,
    output logic       flap,
    output logic       game_run,
    output logic       game_over,
    output logic       score_clear,
    output logic [1:0] state
);

    localparam logic [CW-1:0] COOLDOWN_VAL = CW'(COOLDOWN_TICKS);
    localparam logic [CW-1:0] HOLD_VAL     = CW'(DEAD_HOLD_TICKS);

    game_state_t   state_q;
    logic          key_q;
    logic          press;
    logic          cd_load, cd_zero;
    logic          hold_load, hold_zero;
    logic [CW-1:0] cooldown_cnt, hold_cnt;
    logic          unused_counts;

    assign press = key_level & ~key_q;

    assign cd_load   = press && ((state_q == IDLE) ||
                                 ((state_q == PLAY) && !collide && cd_zero));
    assign hold_load = (state_q == PLAY) && collide;

    tick_down_counter #(.CW(CW)) u_cooldown (
        .clk      (clk),
        .reset    (reset),
        .load     (cd_load),
        .load_val (COOLDOWN_VAL),
        .tick     (tick),
        .count    (cooldown_cnt),
        .zero     (cd_zero)
    );

    tick_down_counter #(.CW(CW)) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .load_val (HOLD_VAL),
        .tick     (tick),
        .count    (hold_cnt),
        .zero     (hold_zero)
    );

    assign unused_counts = ^{cooldown_cnt, hold_cnt};

    // key_q resets high so a key held through reset release is not seen as a press.
    // NOTE: all state here uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            key_q       <= 1'b1;
            flap        <= 1'b0;
            score_clear <= 1'b0;
            game_run    <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            key_q       <= key_level;
            flap        <= 1'b0;
            score_clear <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press) begin
                        state_q     <= PLAY;
                        flap        <= 1'b1;
                        score_clear <= 1'b1;
                        game_run    <= 1'b1;
                    end
                end
                PLAY: begin
                    if (collide) begin
                        state_q   <= DEAD;
                        game_run  <= 1'b0;
                        game_over <= 1'b1;
                    end else if (press && cd_zero) begin
                        flap <= 1'b1;
                    end
                end
                DEAD: begin
                    if (press && hold_zero) begin
                        state_q   <= IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    game_run  <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_flap_controller.sv
// Directed, table-driven bench for flap_controller with hand-computed expectations.
module tb_flap_controller;
    import flappy_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_level;
    logic       tick;
    logic       collide;
    logic       flap;
    logic       game_run;
    logic       game_over;
    logic       score_clear;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       key;
        logic       tk;
        logic       col;
        logic       e_flap;
        logic       e_sc;
        logic       e_run;
        logic       e_over;
        logic [1:0] e_state;
    } vec_t;

    vec_t vecs[$];

    flap_controller dut (
        .clk         (clk),
        .reset       (reset),
        .key_level   (key_level),
        .tick        (tick),
        .collide     (collide),
        .flap        (flap),
        .game_run    (game_run),
        .game_over   (game_over),
        .score_clear (score_clear),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic key, input logic tk, input logic col,
                               input logic f, input logic sc, input logic run,
                               input logic over, input logic [1:0] st);
        vec_t r;
        r.key = key; r.tk = tk; r.col = col;
        r.e_flap = f; r.e_sc = sc; r.e_run = run; r.e_over = over; r.e_state = st;
        return r;
    endfunction

    // Packed view: {flap, score_clear, game_run, game_over, state}
    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={flap,sc,run,over,state}=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {flap, score_clear, game_run, game_over, state};
    endfunction

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;

    initial begin
        // Key held through reset, then held 5 more cycles: no press.
        for (int i = 0; i < 5; i++) vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, S_IDLE));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, S_IDLE));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, S_IDLE));   // collide ignored in IDLE
        vecs.push_back(v(1, 0, 0, 1, 1, 1, 0, S_PLAY));   // start: flap + score_clear
        vecs.push_back(v(1, 0, 0, 0, 0, 1, 0, S_PLAY));   // pulses last one cycle
        vecs.push_back(v(0, 1, 0, 0, 0, 1, 0, S_PLAY));   // cooldown 2->1
        vecs.push_back(v(1, 0, 0, 0, 0, 1, 0, S_PLAY));   // press dropped
        vecs.push_back(v(0, 1, 0, 0, 0, 1, 0, S_PLAY));   // cooldown 1->0
        vecs.push_back(v(1, 0, 0, 1, 0, 1, 0, S_PLAY));   // flap, cooldown=2
        for (int i = 0; i < 3; i++) vecs.push_back(v(0, 1, 0, 0, 0, 1, 0, S_PLAY)); // 1,0,0
        vecs.push_back(v(1, 1, 0, 1, 0, 1, 0, S_PLAY));   // flap; load beats tick -> 2
        vecs.push_back(v(0, 1, 0, 0, 0, 1, 0, S_PLAY));   // 2->1
        vecs.push_back(v(1, 0, 0, 0, 0, 1, 0, S_PLAY));   // dropped, proves load won
        vecs.push_back(v(0, 1, 0, 0, 0, 1, 0, S_PLAY));   // 1->0
        vecs.push_back(v(1, 0, 1, 0, 0, 0, 1, S_DEAD));   // collide beats press
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, S_DEAD));
        for (int i = 0; i < 7; i++) vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, S_DEAD)); // hold 8->1
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, S_DEAD));   // hold=1: press ignored
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, S_DEAD));   // hold 1->0
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, S_IDLE));   // DEAD->IDLE, no pulses
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, S_IDLE));   // held key does not restart
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, S_IDLE));
        vecs.push_back(v(1, 0, 0, 1, 1, 1, 0, S_PLAY));   // second press starts game

        reset     = 1'b1;
        key_level = 1'b1;
        tick      = 1'b0;
        collide   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", outs(), {1'b0, 1'b0, 1'b0, 1'b0, S_IDLE});
        reset = 1'b0;

        foreach (vecs[i]) begin
            key_level = vecs[i].key;
            tick      = vecs[i].tk;
            collide   = vecs[i].col;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].e_flap, vecs[i].e_sc, vecs[i].e_run, vecs[i].e_over, vecs[i].e_state});
        end

        // Mid-PLAY asynchronous reset with flap high and cooldown loaded.
        key_level = 1'b1;
        tick      = 1'b0;
        #2 reset = 1'b1;
        #1 check("async_reset_clear", outs(), {1'b0, 1'b0, 1'b0, 1'b0, S_IDLE});
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("held_after_reset", outs(), {1'b0, 1'b0, 1'b0, 1'b0, S_IDLE});
        key_level = 1'b0;
        @(posedge clk);
        @(negedge clk);
        key_level = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_after_reset", outs(), {1'b1, 1'b1, 1'b1, 1'b0, S_PLAY});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
